// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and constants for the IF/MEM memory bus arbiter slice.
// Holds the arbiter state enum, bus word width, full-lane select and timeout default.
package mem_bus_arbiter_pkg;

  localparam int RegBus = 32;
  typedef logic [RegBus-1:0] reg_bus_t;

  localparam logic [3:0] SEL_ALL            = 4'b1111;
  localparam int         TIMEOUT_CYCLES_DEF = 255;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_ACC  = 2'd1,
    MEM_ACC = 2'd2,
    DRAIN   = 2'd3
  } arb_state_t;

  // Registered bus request as presented on the shared bus.
  typedef struct packed {
    logic       we;
    logic [3:0] sel;
    reg_bus_t   addr;
    reg_bus_t   data;
  } bus_req_t;

  function automatic int cnt_width(input int limit);
    int w;
    w = $clog2(limit + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Shared synchronous-ack memory bus: the arbiter is the master, the memory the slave.
interface mem_bus_arbiter_if;
  import mem_bus_arbiter_pkg::*;

  logic       bus_stb_o;
  logic       bus_we_o;
  logic [3:0] bus_sel_o;
  reg_bus_t   bus_addr_o;
  reg_bus_t   bus_data_o;
  reg_bus_t   bus_data_i;
  logic       bus_ack_i;

  modport master (
    output bus_stb_o,
    output bus_we_o,
    output bus_sel_o,
    output bus_addr_o,
    output bus_data_o,
    input  bus_data_i,
    input  bus_ack_i
  );

  modport slave (
    input  bus_stb_o,
    input  bus_we_o,
    input  bus_sel_o,
    input  bus_addr_o,
    input  bus_data_o,
    output bus_data_i,
    output bus_ack_i
  );

endinterface

// File: rtl/mem_bus_timer.sv
// Ack-wait counter: cleared while clr is high, counts enabled cycles, expire flags the
// cycle in which the LIMIT-th wait cycle completes. Used only with BUS_TIMEOUT_EN.
module mem_bus_timer
  import mem_bus_arbiter_pkg::*;
#(
  parameter int LIMIT = TIMEOUT_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = cnt_width(LIMIT);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expire = en && (cnt == CW'(LIMIT - 1));

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one sync-ack bus between IF and MEM (MEM first); stb registered 1 cycle after request, stall until ack.
// Flush drains an in-flight cycle without data; BUS_TIMEOUT_EN adds an ack timeout with per-port error pulses.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_ce_i,
  input  reg_bus_t          if_addr_i,
  output reg_bus_t          if_data_o,
  output logic              if_stallreq_o,
  input  logic              mem_ce_i,
  input  logic              mem_we_i,
  input  logic [3:0]        mem_sel_i,
  input  reg_bus_t          mem_addr_i,
  input  reg_bus_t          mem_data_i,
  output reg_bus_t          mem_data_o,
  output logic              mem_stallreq_o,
  output logic              if_buserr_o,
  output logic              mem_buserr_o,
  mem_bus_arbiter_if.master bus
);

  arb_state_t state_q, state_d;
  bus_req_t   req_q, req_d;
  logic       stb_q, stb_d;
  reg_bus_t   if_data_q, if_data_d;
  reg_bus_t   mem_data_q, mem_data_d;
  logic       if_err_q, if_err_d;
  logic       mem_err_q, mem_err_d;
  logic       expire;
  logic       if_ack, mem_ack;
  logic       if_req, mem_req;

  assign if_ack  = (state_q == IF_ACC)  && bus.bus_ack_i;
  assign mem_ack = (state_q == MEM_ACC) && bus.bus_ack_i;

  // A port whose access just timed out is released this cycle, so it must not be re-granted.
  assign if_req  = if_ce_i  && !if_err_q;
  assign mem_req = mem_ce_i && !mem_err_q;

`ifdef BUS_TIMEOUT_EN
  mem_bus_timer #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q == IDLE),
    .en     (state_q != IDLE),
    .expire (expire)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign expire             = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    stb_d      = stb_q;
    if_data_d  = if_data_q;
    mem_data_d = mem_data_q;
    if_err_d   = 1'b0;
    mem_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (!flush_i) begin
          if (mem_req) begin
            req_d   = '{we: mem_we_i, sel: mem_sel_i, addr: mem_addr_i, data: mem_data_i};
            stb_d   = 1'b1;
            state_d = MEM_ACC;
          end else if (if_req) begin
            req_d   = '{we: 1'b0, sel: SEL_ALL, addr: if_addr_i, data: '0};
            stb_d   = 1'b1;
            state_d = IF_ACC;
          end
        end
      end

      IF_ACC, MEM_ACC: begin
        if (bus.bus_ack_i) begin
          stb_d   = 1'b0;
          state_d = IDLE;
          // A flush coinciding with the ack completes the cycle but discards its data.
          if (!flush_i) begin
            if (state_q == IF_ACC) begin
              if_data_d = bus.bus_data_i;
            end else begin
              mem_data_d = bus.bus_data_i;
            end
          end
        end else if (expire) begin
          stb_d   = 1'b0;
          state_d = IDLE;
          if (state_q == IF_ACC) begin
            if_data_d = '0;
            if_err_d  = 1'b1;
          end else begin
            mem_data_d = '0;
            mem_err_d  = 1'b1;
          end
        end else if (flush_i) begin
          state_d = DRAIN;
        end
      end

      DRAIN: begin
        if (bus.bus_ack_i || expire) begin
          stb_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        stb_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_q      <= '0;
      stb_q      <= 1'b0;
      if_data_q  <= '0;
      mem_data_q <= '0;
      if_err_q   <= 1'b0;
      mem_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      stb_q      <= stb_d;
      if_data_q  <= if_data_d;
      mem_data_q <= mem_data_d;
      if_err_q   <= if_err_d;
      mem_err_q  <= mem_err_d;
    end
  end

  assign bus.bus_stb_o  = stb_q;
  assign bus.bus_we_o   = req_q.we;
  assign bus.bus_sel_o  = req_q.sel;
  assign bus.bus_addr_o = req_q.addr;
  assign bus.bus_data_o = req_q.data;

  // Read data bypasses the capture register in the owning port's ack cycle.
  assign if_data_o  = (if_ack  && !flush_i) ? bus.bus_data_i : if_data_q;
  assign mem_data_o = (mem_ack && !flush_i) ? bus.bus_data_i : mem_data_q;

  assign if_stallreq_o  = !rst && if_ce_i  && !if_ack  && !flush_i && !if_err_q;
  assign mem_stallreq_o = !rst && mem_ce_i && !mem_ack && !flush_i && !mem_err_q;

  assign if_buserr_o  = if_err_q;
  assign mem_buserr_o = mem_err_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: fetch, MEM-over-IF priority, flush drain, reset mid-access, timeout.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_ce;
  logic [31:0] if_addr;
  logic [31:0] if_data;
  logic        if_stall;
  logic        mem_ce;
  logic        mem_we;
  logic [3:0]  mem_sel;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_data;
  logic        mem_stall;
  logic        if_err;
  logic        mem_err;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  mem_bus_arbiter_if bus_if ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush_i        (flush),
    .if_ce_i        (if_ce),
    .if_addr_i      (if_addr),
    .if_data_o      (if_data),
    .if_stallreq_o  (if_stall),
    .mem_ce_i       (mem_ce),
    .mem_we_i       (mem_we),
    .mem_sel_i      (mem_sel),
    .mem_addr_i     (mem_addr),
    .mem_data_i     (mem_wdata),
    .mem_data_o     (mem_data),
    .mem_stallreq_o (mem_stall),
    .if_buserr_o    (if_err),
    .mem_buserr_o   (mem_err),
    .bus            (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag, input arb_state_t exp);
    chk(tag, 32'(dut.state_q), 32'(exp));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0;
    if_ce = 1'b1; if_addr = '0;
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = '0; mem_addr = '0; mem_wdata = '0;
    bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = '0;

    // Reset: stalls forced low even with requests pending, everything else zero.
    tick();
    smp();
    chk1("rst_if_stall", if_stall, 1'b0);
    chk1("rst_mem_stall", mem_stall, 1'b0);
    chk1("rst_stb", bus_if.bus_stb_o, 1'b0);
    chk1("rst_we", bus_if.bus_we_o, 1'b0);
    chk("rst_sel", 32'(bus_if.bus_sel_o), 32'h0);
    chk("rst_addr", bus_if.bus_addr_o, 32'h0);
    chk("rst_wdata", bus_if.bus_data_o, 32'h0);
    chk("rst_if_data", if_data, 32'h0);
    chk("rst_mem_data", mem_data, 32'h0);
    chk1("rst_if_err", if_err, 1'b0);
    chk1("rst_mem_err", mem_err, 1'b0);
    chk_state("rst_state", IDLE);

    // Fetch with ack in the first bus cycle.
    tick();
    rst = 1'b0; mem_ce = 1'b0; if_ce = 1'b1; if_addr = 32'h0000_0040;
    smp();
    chk1("f_stall_req", if_stall, 1'b1);
    chk1("f_stb_req", bus_if.bus_stb_o, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h3C01_1234;
    smp();
    chk1("f_stb", bus_if.bus_stb_o, 1'b1);
    chk("f_addr", bus_if.bus_addr_o, 32'h0000_0040);
    chk("f_sel", 32'(bus_if.bus_sel_o), 32'hF);
    chk1("f_we", bus_if.bus_we_o, 1'b0);
    chk("f_data_bypass", if_data, 32'h3C01_1234);
    chk1("f_stall_ack", if_stall, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b0; bus_if.bus_data_i = 32'hFFFF_FFFF; if_ce = 1'b0;
    smp();
    chk1("f_stb_done", bus_if.bus_stb_o, 1'b0);
    chk("f_data_held", if_data, 32'h3C01_1234);
    chk_state("f_state_idle", IDLE);

    // Simultaneous MEM store and IF fetch: MEM first, IF after one bubble.
    tick();
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF;
    if_ce = 1'b1; if_addr = 32'h0000_0044;
    smp();
    chk1("s_mem_stall0", mem_stall, 1'b1);
    chk1("s_if_stall0", if_stall, 1'b1);
    tick();
    smp();
    chk1("s_stb1", bus_if.bus_stb_o, 1'b1);
    chk1("s_we1", bus_if.bus_we_o, 1'b1);
    chk("s_sel1", 32'(bus_if.bus_sel_o), 32'h3);
    chk("s_addr1", bus_if.bus_addr_o, 32'h0000_0100);
    chk("s_wdata1", bus_if.bus_data_o, 32'hDEAD_BEEF);
    chk1("s_mem_stall1", mem_stall, 1'b1);
    chk1("s_if_stall1", if_stall, 1'b1);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h5555_AAAA;
    smp();
    chk1("s_stb_hold", bus_if.bus_stb_o, 1'b1);
    chk("s_addr_hold", bus_if.bus_addr_o, 32'h0000_0100);
    chk1("s_mem_stall_ack", mem_stall, 1'b0);
    chk1("s_if_stall_ack", if_stall, 1'b1);
    chk("s_mem_bypass", mem_data, 32'h5555_AAAA);
    tick();
    bus_if.bus_ack_i = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    smp();
    chk1("s_bubble_stb", bus_if.bus_stb_o, 1'b0);
    chk_state("s_bubble_state", IDLE);
    chk1("s_bubble_if_stall", if_stall, 1'b1);
    chk("s_mem_held", mem_data, 32'h5555_AAAA);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h8C02_0000;
    smp();
    chk1("s_if_stb", bus_if.bus_stb_o, 1'b1);
    chk("s_if_addr", bus_if.bus_addr_o, 32'h0000_0044);
    chk1("s_if_we", bus_if.bus_we_o, 1'b0);
    chk("s_if_sel", 32'(bus_if.bus_sel_o), 32'hF);
    chk("s_if_data", if_data, 32'h8C02_0000);
    chk1("s_if_stall_done", if_stall, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b0; if_ce = 1'b0;

    // Flush during a MEM load: drain until ack, data discarded, no early grant.
    tick();
    mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'b1111; mem_addr = 32'h0000_0200;
    tick();
    smp();
    chk1("d_stb1", bus_if.bus_stb_o, 1'b1);
    chk_state("d_state1", MEM_ACC);
    tick();
    flush = 1'b1;
    smp();
    chk1("d_stall_flush", mem_stall, 1'b0);
    tick();
    flush = 1'b0; mem_ce = 1'b0; if_ce = 1'b1; if_addr = 32'h0000_0048;
    smp();
    chk_state("d_state3", DRAIN);
    chk1("d_stb3", bus_if.bus_stb_o, 1'b1);
    chk("d_addr3", bus_if.bus_addr_o, 32'h0000_0200);
    chk1("d_if_stall3", if_stall, 1'b1);
    chk("d_mem_data3", mem_data, 32'h5555_AAAA);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h1234_5678;
    smp();
    chk1("d_stb4", bus_if.bus_stb_o, 1'b1);
    chk("d_mem_data4", mem_data, 32'h5555_AAAA);
    chk1("d_if_stall4", if_stall, 1'b1);
    tick();
    bus_if.bus_ack_i = 1'b0;
    smp();
    chk1("d_stb5", bus_if.bus_stb_o, 1'b0);
    chk_state("d_state5", IDLE);
    chk("d_mem_data5", mem_data, 32'h5555_AAAA);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h0000_0013;
    smp();
    chk_state("d_state6", IF_ACC);
    chk("d_addr6", bus_if.bus_addr_o, 32'h0000_0048);
    chk("d_if_data6", if_data, 32'h0000_0013);
    // Ack while idle must be ignored.
    tick();
    if_ce = 1'b0; bus_if.bus_data_i = 32'hBAD0_BAD0;
    smp();
    chk1("i_stb", bus_if.bus_stb_o, 1'b0);
    chk("i_if_data", if_data, 32'h0000_0013);
    chk("i_mem_data", mem_data, 32'h5555_AAAA);
    tick();
    bus_if.bus_ack_i = 1'b0;
    smp();
    chk_state("i_state", IDLE);
    chk("i_if_data_held", if_data, 32'h0000_0013);

    // Synchronous reset in the middle of a MEM access, then a normal fetch.
    tick();
    mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b1100; mem_addr = 32'h0000_0300; mem_wdata = 32'hCAFE_F00D;
    tick();
    rst = 1'b1; if_ce = 1'b1; if_addr = 32'h0000_0304;
    smp();
    chk1("r_stb_pre", bus_if.bus_stb_o, 1'b1);
    chk1("r_mem_stall_rst", mem_stall, 1'b0);
    chk1("r_if_stall_rst", if_stall, 1'b0);
    tick();
    rst = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
    smp();
    chk1("r_stb", bus_if.bus_stb_o, 1'b0);
    chk1("r_we", bus_if.bus_we_o, 1'b0);
    chk("r_sel", 32'(bus_if.bus_sel_o), 32'h0);
    chk("r_addr", bus_if.bus_addr_o, 32'h0);
    chk("r_wdata", bus_if.bus_data_o, 32'h0);
    chk("r_if_data", if_data, 32'h0);
    chk("r_mem_data", mem_data, 32'h0);
    chk_state("r_state", IDLE);
    tick();
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h0BAD_CAFE;
    smp();
    chk1("r2_stb", bus_if.bus_stb_o, 1'b1);
    chk("r2_addr", bus_if.bus_addr_o, 32'h0000_0304);
    chk("r2_if_data", if_data, 32'h0BAD_CAFE);
    chk1("r2_if_stall", if_stall, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b0; if_ce = 1'b0;

    // Fetch that is never acked.
    tick();
    if_ce = 1'b1; if_addr = 32'h0000_0080;
    for (int i = 0; i < 4; i++) begin
      tick();
      smp();
      chk1("t_wait_stb", bus_if.bus_stb_o, 1'b1);
      chk1("t_wait_err", if_err, 1'b0);
    end
    tick();
`ifdef BUS_TIMEOUT_EN
    smp();
    chk1("t_err", if_err, 1'b1);
    chk1("t_mem_err", mem_err, 1'b0);
    chk("t_if_data", if_data, 32'h0);
    chk1("t_stb", bus_if.bus_stb_o, 1'b0);
    chk1("t_if_stall", if_stall, 1'b0);
    chk_state("t_state", IDLE);
    tick();
    if_ce = 1'b0;
    smp();
    chk1("t_err_end", if_err, 1'b0);
    chk1("t_stb_end", bus_if.bus_stb_o, 1'b0);
`else
    bus_if.bus_ack_i = 1'b1; bus_if.bus_data_i = 32'h0000_0077;
    smp();
    chk1("t_stb_still", bus_if.bus_stb_o, 1'b1);
    chk1("t_err_none", if_err, 1'b0);
    chk("t_if_data", if_data, 32'h0000_0077);
    chk1("t_if_stall", if_stall, 1'b0);
    tick();
    bus_if.bus_ack_i = 1'b0; if_ce = 1'b0;
    smp();
    chk1("t_stb_end", bus_if.bus_stb_o, 1'b0);
`endif

    if (n_fail != 0) $display("checks not matching: %0d", n_fail);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
